// File: rtl/fpmul_master.sv
// fpmul_master: initiator side of the FP multiplier handshake.
// Queues operand pairs in a small FIFO, issues them one at a time to a
// non-pipelined multiplier, collects each product (or a timeout abort) and
// reports it with an 8-bit sequence index.
// Optional build macro: FPMUL_MASTER_CLASS_EN enables result classification
// on out_class_o (zero / infinity / NaN); without it out_class_o is tied to 0.
module fpmul_master #(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          op_wr_i,
    input  logic [DW-1:0] op_a_i,
    input  logic [DW-1:0] op_b_i,
    output logic          op_full_o,
    output logic          op_ovf_o,
    output logic          mul_valid_o,
    output logic [DW-1:0] mul_a_o,
    output logic [DW-1:0] mul_b_o,
    input  logic          mul_ready_i,
    input  logic          res_valid_i,
    input  logic [DW-1:0] res_data_i,
    output logic          res_ready_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    output logic [7:0]    out_idx_o,
    output logic          out_err_o,
    output logic [2:0]    out_class_o,
    output logic          busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TLAST_C = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // ---------------- operand FIFO ----------------
    logic [DW-1:0] mem_a_q [FIFO_DEPTH];
    logic [DW-1:0] mem_b_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ovf_q;
    logic          full;
    logic          push;
    logic          pop;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when the FSM is popping.
    assign full = (cnt_q == DEPTH_C);
    assign push = op_wr_i && (!full || pop);
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    // FIFO storage carries data only, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= op_a_i;
            mem_b_q[wr_ptr_q] <= op_b_i;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
            if (op_wr_i && full && !pop) ovf_q <= 1'b1;
        end
    end

    // ---------------- transaction FSM ----------------
    state_t        state_q,     state_d;
    logic          mul_valid_q, mul_valid_d;
    logic [DW-1:0] mul_a_q,     mul_a_d;
    logic [DW-1:0] mul_b_q,     mul_b_d;
    logic          res_ready_q, res_ready_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [7:0]    seq_q,       seq_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic [7:0]    out_idx_q,   out_idx_d;
    logic          out_err_q,   out_err_d;
    logic          cap_res;
    logic          cap_abort;

    // A result arriving on the last timer cycle takes priority over the abort.
    assign cap_res   = (state_q == S_WAIT) && res_valid_i && res_ready_q;
    assign cap_abort = (state_q == S_WAIT) && !cap_res && (timer_q == TLAST_C);

    // Next-state and registered-output logic for the issue/collect sequence.
    always_comb begin
        state_d     = state_q;
        mul_valid_d = mul_valid_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        res_ready_d = res_ready_q;
        timer_d     = timer_q;
        seq_d       = seq_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_err_d   = out_err_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    pop         = 1'b1;
                    mul_a_d     = mem_a_q[rd_ptr_q];
                    mul_b_d     = mem_b_q[rd_ptr_q];
                    mul_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Operands stay frozen until the multiplier takes them.
                if (mul_valid_q && mul_ready_i) begin
                    mul_valid_d = 1'b0;
                    res_ready_d = 1'b1;
                    timer_d     = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cap_res) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_data_i;
                    out_err_d   = 1'b0;
                    out_idx_d   = seq_q;
                    res_ready_d = 1'b0;
                    seq_d       = seq_q + 8'd1;
                    state_d     = S_IDLE;
                end else if (cap_abort) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_err_d   = 1'b1;
                    out_idx_d   = seq_q;
                    res_ready_d = 1'b0;
                    seq_d       = seq_q + 8'd1;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and all handshake/report registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_ready_q <= 1'b0;
            timer_q     <= '0;
            seq_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res_ready_q <= res_ready_d;
            timer_q     <= timer_d;
            seq_q       <= seq_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_err_q   <= out_err_d;
        end
    end

`ifdef FPMUL_MASTER_CLASS_EN
    logic [2:0] out_class_q;

    // IEEE-754 single classification: {NaN, infinity, zero}.
    function automatic logic [2:0] class_of(input logic [DW-1:0] v);
        logic [7:0]  e;
        logic [22:0] f;
        e = v[30:23];
        f = v[22:0];
        class_of = {(e == 8'hFF) && (f != '0),
                    (e == 8'hFF) && (f == '0),
                    (e == 8'h00) && (f == '0)};
    endfunction

    // Class is captured together with the product; an abort reports none.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_class_q <= 3'b000;
        end else if (cap_res) begin
            out_class_q <= class_of(res_data_i);
        end else if (cap_abort) begin
            out_class_q <= 3'b000;
        end
    end

    assign out_class_o = out_class_q;
`else
    assign out_class_o = 3'b000;
`endif

    assign op_full_o   = full;
    assign op_ovf_o    = ovf_q;
    assign mul_valid_o = mul_valid_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign res_ready_o = res_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign out_err_o   = out_err_q;
    assign busy_o      = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_fpmul_master.sv
// tb_fpmul_master: directed bench for fpmul_master with a hand-driven
// multiplier responder. Class expectations follow FPMUL_MASTER_CLASS_EN.
module tb_fpmul_master;

    localparam int DW = 32;
    localparam int FD = 4;
    localparam int TO = 64;

`ifdef FPMUL_MASTER_CLASS_EN
    localparam logic [2:0] CLS_ZERO = 3'b001;
    localparam logic [2:0] CLS_INF  = 3'b010;
    localparam logic [2:0] CLS_NAN  = 3'b100;
`else
    localparam logic [2:0] CLS_ZERO = 3'b000;
    localparam logic [2:0] CLS_INF  = 3'b000;
    localparam logic [2:0] CLS_NAN  = 3'b000;
`endif

    logic          clk;
    logic          rst_n;
    logic          op_wr;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_full;
    logic          op_ovf;
    logic          mul_valid;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic          mul_ready;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [7:0]    out_idx;
    logic          out_err;
    logic [2:0]    out_class;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    fpmul_master #(
        .DW(DW), .FIFO_DEPTH(FD), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .op_wr_i(op_wr), .op_a_i(op_a), .op_b_i(op_b),
        .op_full_o(op_full), .op_ovf_o(op_ovf),
        .mul_valid_o(mul_valid), .mul_a_o(mul_a), .mul_b_o(mul_b),
        .mul_ready_i(mul_ready),
        .res_valid_i(res_valid), .res_data_i(res_data), .res_ready_o(res_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_idx_o(out_idx),
        .out_err_o(out_err), .out_class_o(out_class), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        op_a  = a;
        op_b  = b;
        op_wr = 1'b1;
        tick();
        op_wr = 1'b0;
    endtask

    task automatic wait_mv(output bit ok);
        int n;
        n = 0;
        while (!mul_valid && n < 40) begin
            tick();
            n++;
        end
        ok = mul_valid;
        if (!ok) check("mv_wait", 32'(mul_valid), 32'd1);
    endtask

    // Accept after acc_d cycles, return rv res_d cycles later, check report.
    task automatic serve(input int acc_d, input int res_d, input logic [31:0] rv,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic [7:0] eidx, input logic [2:0] ecls);
        bit ok;
        wait_mv(ok);
        if (!ok) return;
        check("mul_a", mul_a, ea);
        check("mul_b", mul_b, eb);
        for (int k = 0; k < acc_d; k++) begin
            tick();
            check("hold_mv", 32'(mul_valid), 32'd1);
            check("hold_a", mul_a, ea);
            check("hold_b", mul_b, eb);
        end
        mul_ready = 1'b1;
        tick();
        mul_ready = 1'b0;
        check("acc_mv", 32'(mul_valid), 32'd0);
        check("acc_rr", 32'(res_ready), 32'd1);
        for (int k = 0; k < res_d; k++) tick();
        res_valid = 1'b1;
        res_data  = rv;
        tick();
        res_valid = 1'b0;
        check("ov", 32'(out_valid), 32'd1);
        check("odata", out_data, rv);
        check("oidx", 32'(out_idx), 32'(eidx));
        check("oerr", 32'(out_err), 32'd0);
        check("ocls", 32'(out_class), 32'(ecls));
        check("rr_off", 32'(res_ready), 32'd0);
    endtask

    // Accept immediately and never answer; expect the timeout abort.
    task automatic serve_to(input logic [31:0] ea, input logic [7:0] eidx);
        bit ok;
        int n;
        wait_mv(ok);
        if (!ok) return;
        check("to_mul_a", mul_a, ea);
        mul_ready = 1'b1;
        tick();
        mul_ready = 1'b0;
        n = 0;
        while (!out_valid && n < TO + 8) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), 32'(TO));
        check("to_err", 32'(out_err), 32'd1);
        check("to_data", out_data, 32'd0);
        check("to_idx", 32'(out_idx), 32'(eidx));
        check("to_cls", 32'(out_class), 32'd0);
        check("to_rr", 32'(res_ready), 32'd0);
    endtask

    initial begin
        bit ok;
        int cnt;
        rst_n     = 1'b0;
        op_wr     = 1'b0;
        op_a      = '0;
        op_b      = '0;
        mul_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        repeat (3) tick();

        // Reset state
        check("rst_mv", 32'(mul_valid), 32'd0);
        check("rst_ma", mul_a, 32'd0);
        check("rst_rr", 32'(res_ready), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_od", out_data, 32'd0);
        check("rst_oi", 32'(out_idx), 32'd0);
        check("rst_oe", 32'(out_err), 32'd0);
        check("rst_oc", 32'(out_class), 32'd0);
        check("rst_full", 32'(op_full), 32'd0);
        check("rst_ovf", 32'(op_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single transaction: 2.0 * 3.0 = 6.0, issue latency 2 cycles
        push(32'h40000000, 32'h40400000);
        check("lat_mv0", 32'(mul_valid), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        tick();
        check("lat_mv1", 32'(mul_valid), 32'd1);
        serve(1, 5, 32'h40C00000, 32'h40000000, 32'h40400000, 8'd0, 3'b000);
        check("t1_busy", 32'(busy), 32'd0);
        tick();
        check("pulse", 32'(out_valid), 32'd0);

        // Overflow with the multiplier stalled: one in flight, four queued, one dropped
        for (int i = 0; i < 6; i++) begin
            op_a  = 32'h11110000 + 32'(i);
            op_b  = 32'h22220000 + 32'(i);
            op_wr = 1'b1;
            if (i == 5) begin
                check("full_pre", 32'(op_full), 32'd1);
                check("ovf_pre", 32'(op_ovf), 32'd0);
            end
            tick();
        end
        op_wr = 1'b0;
        check("full", 32'(op_full), 32'd1);
        check("ovf", 32'(op_ovf), 32'd1);
        for (int i = 0; i < 5; i++)
            serve(0, 1, 32'h33330000 + 32'(i), 32'h11110000 + 32'(i),
                  32'h22220000 + 32'(i), 8'(1 + i), 3'b000);
        check("ovf_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("no_extra", 32'(mul_valid), 32'd0);
        check("ovf_sticky", 32'(op_ovf), 32'd1);
        check("full_clr", 32'(op_full), 32'd0);

        // Multiplier not ready for 10 cycles
        push(32'h3FC00000, 32'h40000000);
        serve(10, 2, 32'h40400000, 32'h3FC00000, 32'h40000000, 8'd6, 3'b000);

        // Timeout abort, then the next queued pair is issued
        push(32'hAAAA0001, 32'hBBBB0001);
        push(32'hAAAA0002, 32'hBBBB0002);
        serve_to(32'hAAAA0001, 8'd7);
        serve(1, 3, 32'h5555AAAA, 32'hAAAA0002, 32'hBBBB0002, 8'd8, 3'b000);

        // Result classes
        push(32'h7F000000, 32'h40000000);
        push(32'h7F800000, 32'h00000000);
        push(32'h00000000, 32'h3F800000);
        serve(0, 1, 32'h7F800000, 32'h7F000000, 32'h40000000, 8'd9, CLS_INF);
        serve(0, 1, 32'h7FC00000, 32'h7F800000, 32'h00000000, 8'd10, CLS_NAN);
        serve(0, 1, 32'h00000000, 32'h00000000, 32'h3F800000, 8'd11, CLS_ZERO);

        // Result on the very last timer cycle beats the timeout
        push(32'h01020304, 32'h05060708);
        serve(0, TO - 1, 32'h12345678, 32'h01020304, 32'h05060708, 8'd12, 3'b000);

        // Stray result while idle is ignored
        tick();
        res_valid = 1'b1;
        res_data  = 32'hDEADBEEF;
        check("stray_rr", 32'(res_ready), 32'd0);
        tick();
        res_valid = 1'b0;
        check("stray_ov", 32'(out_valid), 32'd0);
        check("stray_od", out_data, 32'h12345678);

        // Asynchronous reset while waiting for a result
        push(32'h0A0A0A0A, 32'h0B0B0B0B);
        push(32'h0C0C0C0C, 32'h0D0D0D0D);
        wait_mv(ok);
        mul_ready = 1'b1;
        tick();
        mul_ready = 1'b0;
        check("wr_rr", 32'(res_ready), 32'd1);
        check("wr_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_rr", 32'(res_ready), 32'd0);
        check("ar_mv", 32'(mul_valid), 32'd0);
        check("ar_ov", 32'(out_valid), 32'd0);
        check("ar_od", out_data, 32'd0);
        check("ar_oi", 32'(out_idx), 32'd0);
        check("ar_ovf", 32'(op_ovf), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("ar_no_ov", 32'(cnt), 32'd0);
        check("ar_busy2", 32'(busy), 32'd0);
        check("ar_mv2", 32'(mul_valid), 32'd0);

        // Sequence index restarts at 0 and wraps 255 -> 0
        for (int i = 0; i < 257; i++) begin
            push(32'h3F800000 + 32'(i), 32'h40000000 + 32'(i));
            serve(0, 0, 32'h3F000000 + 32'(i), 32'h3F800000 + 32'(i),
                  32'h40000000 + 32'(i), 8'(i), 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
